bcd_down_counter: RTL and testbench

//  Cascaded multi-digit BCD down-counter: the count-down counterpart of the team's BCD up-counter.

---
 rtl/bcd_down_counter.sv | 92 +++++++++
 tb/tb_bcd_down_counter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_down_counter.sv
// Cascaded multi-digit BCD down-counter with parallel load, decimal borrow
// chain, zero flag, terminal-count pulse and optional auto-reload of the
// last loaded start value. All state changes on the falling edge of CLK.
module bcd_down_counter #(
   parameter int DIGITS = 2
) (
   input  logic                  CLK,
   input  logic                  RES,
   input  logic                  EN,
   input  logic                  LOAD,
   input  logic [4*DIGITS-1:0]   LOAD_VAL,
   input  logic                  AUTO_RELOAD,
   output logic [4*DIGITS-1:0]   Q,
   output logic                  ZERO,
   output logic                  TC,
   output logic                  LOAD_ERR
);

   localparam int W = 4 * DIGITS;

   logic [W-1:0] reload_val;
   logic [W-1:0] clamped_val;
   logic         clamp_hit;
   logic [W-1:0] dec_val;
   logic         borrow;
   logic         is_one;

   // Clamp every load nibble above 9 down to 9 and flag that it happened
   always_comb begin
      clamped_val = '0;
      clamp_hit   = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (LOAD_VAL[4*i +: 4] > 4'd9) begin
            clamped_val[4*i +: 4] = 4'd9;
            clamp_hit             = 1'b1;
         end else begin
            clamped_val[4*i +: 4] = LOAD_VAL[4*i +: 4];
         end
      end
   end

   // BCD decrement: a zero digit becomes 9 and passes the borrow upward
   always_comb begin
      dec_val = Q;
      borrow  = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (Q[4*i +: 4] == 4'd0) begin
               dec_val[4*i +: 4] = 4'd9;
            end else begin
               dec_val[4*i +: 4] = Q[4*i +: 4] - 4'd1;
               borrow            = 1'b0;
            end
         end
      end
   end

   assign ZERO   = (Q == '0);
   assign is_one = (Q == W'(1));

   // Count register, reload register and the two pulse flags; load beats
   // count, and a zero count either reloads or holds (never wraps to 9s)
   always_ff @(negedge CLK or posedge RES) begin
      if (RES) begin
         Q          <= '0;
         reload_val <= '0;
         TC         <= 1'b0;
         LOAD_ERR   <= 1'b0;
      end else if (LOAD) begin
         Q          <= clamped_val;
         reload_val <= clamped_val;
         TC         <= 1'b0;
         LOAD_ERR   <= clamp_hit;
      end else begin
         LOAD_ERR <= 1'b0;
         if (EN) begin
            if (!ZERO) begin
               Q  <= dec_val;
               TC <= is_one;
            end else begin
               if (AUTO_RELOAD) begin
                  Q <= reload_val;
               end
               TC <= 1'b0;
            end
         end else begin
            TC <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed testbench for bcd_down_counter: a 2-digit instance for the main
// scenarios and a 3-digit instance for the full borrow ripple.
module tb_bcd_down_counter;

   logic        CLK = 1'b0;
   logic        RES = 1'b0;
   logic        en = 1'b0, load = 1'b0, ar = 1'b0;
   logic [7:0]  loadVal = 8'h00;
   logic [7:0]  q;
   logic        zero, tc, loadErr;

   logic        en3 = 1'b0, load3 = 1'b0;
   logic [11:0] loadVal3 = 12'h000;
   logic [11:0] q3;
   logic        zero3, tc3, loadErr3;

   int total = 0;
   int bad   = 0;
   int expVal = 0;
   int expReload = 0;
   int tcCount = 0;

   bcd_down_counter #(.DIGITS(2)) dut (
      .CLK(CLK), .RES(RES), .EN(en), .LOAD(load), .LOAD_VAL(loadVal),
      .AUTO_RELOAD(ar), .Q(q), .ZERO(zero), .TC(tc), .LOAD_ERR(loadErr)
   );

   bcd_down_counter #(.DIGITS(3)) dut3 (
      .CLK(CLK), .RES(RES), .EN(en3), .LOAD(load3), .LOAD_VAL(loadVal3),
      .AUTO_RELOAD(1'b0), .Q(q3), .ZERO(zero3), .TC(tc3), .LOAD_ERR(loadErr3)
   );

   // Free-running clock; the design acts on its falling edge
   always #5 CLK = ~CLK;

   function automatic logic [7:0] toBcd2(input int v);
      logic [7:0] t;
      t[7:4] = 4'(v / 10);
      t[3:0] = 4'(v % 10);
      return t;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one set of inputs, let one falling edge pass, settle 1 time unit
   task automatic applyStimulus(input logic ld, input logic [7:0] val, input logic e, input logic a);
      load    = ld;
      loadVal = val;
      en      = e;
      ar      = a;
      @(negedge CLK);
      #1;
   endtask

   // Count n edges against a decimal reference of the counter
   task automatic runCount(input int n, input logic a);
      logic expTc;
      for (int k = 0; k < n; k++) begin
         applyStimulus(1'b0, 8'h00, 1'b1, a);
         if (expVal == 0) begin
            if (a) expVal = expReload;
            expTc = 1'b0;
         end else begin
            expVal = expVal - 1;
            expTc  = (expVal == 0);
         end
         if (expTc) tcCount++;
         checkOutput("count_q", 32'(q), 32'(toBcd2(expVal)));
         checkOutput("count_tc", 32'(tc), 32'(expTc));
         checkOutput("count_zero", 32'(zero), 32'(expVal == 0));
      end
   endtask

   initial begin
      // Asynchronous reset before any clock edge
      #2 RES = 1'b1;
      #1;
      checkOutput("rst_q", 32'(q), 32'h00);
      checkOutput("rst_zero", 32'(zero), 32'd1);
      checkOutput("rst_tc", 32'(tc), 32'd0);
      checkOutput("rst_lerr", 32'(loadErr), 32'd0);
      @(negedge CLK);
      #1 RES = 1'b0;

      // Mid-count reset takes effect between edges
      applyStimulus(1'b1, 8'h37, 1'b0, 1'b0);
      checkOutput("load37_q", 32'(q), 32'h37);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("dec36_q", 32'(q), 32'h36);
      #2 RES = 1'b1;
      #1;
      checkOutput("async_q", 32'(q), 32'h00);
      checkOutput("async_zero", 32'(zero), 32'd1);
      checkOutput("async_tc", 32'(tc), 32'd0);
      #1 RES = 1'b0;
      expVal = 0;
      expReload = 0;

      // Load 25 and count 30 edges without auto-reload: hold at 00, one TC
      applyStimulus(1'b1, 8'h25, 1'b0, 1'b0);
      checkOutput("load25_q", 32'(q), 32'h25);
      checkOutput("load25_tc", 32'(tc), 32'd0);
      expVal = 25;
      expReload = 25;
      tcCount = 0;
      runCount(30, 1'b0);
      checkOutput("tc_once", 32'(tcCount), 32'd1);

      // Auto-reload from 03: period of four edges
      applyStimulus(1'b1, 8'h03, 1'b0, 1'b1);
      checkOutput("load03_q", 32'(q), 32'h03);
      expVal = 3;
      expReload = 3;
      runCount(9, 1'b1);

      // Clamped load and LOAD_ERR pulse
      applyStimulus(1'b1, 8'hA7, 1'b0, 1'b0);
      checkOutput("clampA7_q", 32'(q), 32'h97);
      checkOutput("clampA7_lerr", 32'(loadErr), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("after_clamp_q", 32'(q), 32'h96);
      checkOutput("after_clamp_lerr", 32'(loadErr), 32'd0);
      applyStimulus(1'b1, 8'h9F, 1'b0, 1'b0);
      checkOutput("clamp9F_q", 32'(q), 32'h99);
      checkOutput("clamp9F_lerr", 32'(loadErr), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("hold_q", 32'(q), 32'h99);
      checkOutput("hold_lerr", 32'(loadErr), 32'd0);

      // Load wins over enable on the same edge
      applyStimulus(1'b1, 8'h50, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h12, 1'b1, 1'b0);
      checkOutput("load_prio_q", 32'(q), 32'h12);
      checkOutput("load_prio_tc", 32'(tc), 32'd0);

      // Auto-reload enabled mid-count only matters once the count hits zero
      applyStimulus(1'b1, 8'h02, 1'b0, 1'b0);
      expVal = 2;
      expReload = 2;
      runCount(1, 1'b0);
      runCount(3, 1'b1);

      // Reload register of zero: stays at zero, no TC
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b1);
      checkOutput("load00_tc", 32'(tc), 32'd0);
      expVal = 0;
      expReload = 0;
      runCount(3, 1'b1);

      // Reset during a load clears the reload register too
      applyStimulus(1'b1, 8'h45, 1'b0, 1'b1);
      load = 1'b1;
      loadVal = 8'h66;
      #2 RES = 1'b1;
      #1;
      checkOutput("rst_in_load_q", 32'(q), 32'h00);
      @(negedge CLK);
      #1 RES = 1'b0;
      expVal = 0;
      expReload = 0;
      runCount(2, 1'b1);

      // Three-digit full borrow ripple and zero load
      load3 = 1'b1;
      loadVal3 = 12'h100;
      @(negedge CLK);
      #1;
      checkOutput("d3_load_q", 32'(q3), 32'h100);
      load3 = 1'b0;
      en3 = 1'b1;
      @(negedge CLK);
      #1;
      checkOutput("d3_ripple_q", 32'(q3), 32'h099);
      load3 = 1'b1;
      loadVal3 = 12'h000;
      @(negedge CLK);
      #1;
      checkOutput("d3_zero_q", 32'(q3), 32'h000);
      checkOutput("d3_zero_flag", 32'(zero3), 32'd1);
      checkOutput("d3_zero_tc", 32'(tc3), 32'd0);
      loadVal3 = 12'h001;
      @(negedge CLK);
      #1;
      load3 = 1'b0;
      @(negedge CLK);
      #1;
      checkOutput("d3_tc_q", 32'(q3), 32'h000);
      checkOutput("d3_tc", 32'(tc3), 32'd1);
      @(negedge CLK);
      #1;
      checkOutput("d3_tc_clear", 32'(tc3), 32'd0);
      checkOutput("d3_lerr", 32'(loadErr3), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
